// File: rtl/umai_mem_target.sv
// Memory-backed UMAI target. Stores write bursts in a flop array and returns them on read bursts.
// Define UMAI_MEM_TARGET_PERF_CNT_EN to enable the saturating beat counters.
module umai_mem_target #(
    parameter int unsigned DataWidth = 512,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned LenWidth  = 6,
    parameter int unsigned Depth     = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_umai_wcmd_valid,
    output logic                 o_umai_wcmd_ready,
    input  logic [AddrWidth-1:0] i_umai_wcmd_addr,
    input  logic [LenWidth-1:0]  i_umai_wcmd_len,
    input  logic                 i_umai_rcmd_valid,
    output logic                 o_umai_rcmd_ready,
    input  logic [AddrWidth-1:0] i_umai_rcmd_addr,
    input  logic [LenWidth-1:0]  i_umai_rcmd_len,
    input  logic                 i_umai_wvalid,
    output logic                 o_umai_wready,
    input  logic [DataWidth-1:0] i_umai_wdata,
    output logic                 o_umai_rvalid,
    input  logic                 i_umai_rready,
    output logic [DataWidth-1:0] o_umai_rdata,
    output logic [31:0]          o_wr_beats,
    output logic [31:0]          o_rd_beats
);
    localparam int unsigned PtrW = $clog2(Depth);

    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;
    typedef enum logic {PrioW, PrioR} prio_e;

    state_e                state_q, state_d;
    prio_e                 prio_q, prio_d;
    logic [PtrW-1:0]       ptr_q, ptr_d, ptr_nxt;
    logic [LenWidth-1:0]   cnt_q, cnt_d;
    logic                  rvalid_q, rvalid_d;
    logic [DataWidth-1:0]  rdata_q, rdata_d;
    logic                  mem_we;
    logic                  wr_beat, rd_beat;
    logic [DataWidth-1:0]  mem [Depth];

    // Upper address bits select nothing; the memory aliases across them.
    logic unused_addr;
    assign unused_addr = ^{i_umai_wcmd_addr[AddrWidth-1:PtrW], i_umai_rcmd_addr[AddrWidth-1:PtrW]};

    assign ptr_nxt = ptr_q + PtrW'(1);
    assign wr_beat = (state_q == StWrite) && i_umai_wvalid;
    assign rd_beat = (state_q == StRead) && rvalid_q && i_umai_rready;

    always_comb begin
        state_d           = state_q;
        prio_d            = prio_q;
        ptr_d             = ptr_q;
        cnt_d             = cnt_q;
        rvalid_d          = rvalid_q;
        rdata_d           = rdata_q;
        mem_we            = 1'b0;
        o_umai_wcmd_ready = 1'b0;
        o_umai_rcmd_ready = 1'b0;
        o_umai_wready     = 1'b0;
        unique case (state_q)
            StIdle: begin
                o_umai_wcmd_ready = !i_umai_rcmd_valid || (prio_q == PrioW);
                o_umai_rcmd_ready = !i_umai_wcmd_valid || (prio_q == PrioR);
                if (i_umai_wcmd_valid && o_umai_wcmd_ready) begin
                    state_d = StWrite;
                    ptr_d   = i_umai_wcmd_addr[PtrW-1:0];
                    cnt_d   = i_umai_wcmd_len;
                end else if (i_umai_rcmd_valid && o_umai_rcmd_ready) begin
                    state_d  = StRead;
                    ptr_d    = i_umai_rcmd_addr[PtrW-1:0];
                    cnt_d    = i_umai_rcmd_len;
                    rvalid_d = 1'b1;
                    rdata_d  = mem[i_umai_rcmd_addr[PtrW-1:0]];
                end
                // Only contention moves the round-robin pointer.
                if (i_umai_wcmd_valid && i_umai_rcmd_valid) begin
                    prio_d = (prio_q == PrioW) ? PrioR : PrioW;
                end
            end
            StWrite: begin
                o_umai_wready = 1'b1;
                if (i_umai_wvalid) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_nxt;
                    cnt_d  = cnt_q - LenWidth'(1);
                    if (cnt_q == '0) state_d = StIdle;
                end
            end
            StRead: begin
                if (rd_beat) begin
                    if (cnt_q == '0) begin
                        rvalid_d = 1'b0;
                        state_d  = StIdle;
                    end else begin
                        rdata_d = mem[ptr_nxt];
                        ptr_d   = ptr_nxt;
                        cnt_d   = cnt_q - LenWidth'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            prio_q   <= PrioW;
            ptr_q    <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) mem[ptr_q] <= i_umai_wdata;
    end

    assign o_umai_rvalid = rvalid_q;
    assign o_umai_rdata  = rdata_q;

`ifdef UMAI_MEM_TARGET_PERF_CNT_EN
    logic [31:0] wr_beats_q, rd_beats_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_beats_q <= '0;
            rd_beats_q <= '0;
        end else begin
            if (wr_beat && (wr_beats_q != '1)) wr_beats_q <= wr_beats_q + 32'd1;
            if (rd_beat && (rd_beats_q != '1)) rd_beats_q <= rd_beats_q + 32'd1;
        end
    end

    assign o_wr_beats = wr_beats_q;
    assign o_rd_beats = rd_beats_q;
`else
    logic unused_beats;
    assign unused_beats = wr_beat ^ rd_beat;
    assign o_wr_beats   = '0;
    assign o_rd_beats   = '0;
`endif

endmodule

// File: tb/tb_umai_mem_target.sv
// Self-checking bench for umai_mem_target: directed scenarios plus randomized bursts checked
// against a word-array reference model with a round-robin winner flag.
module tb_umai_mem_target;
    localparam int DW    = 64;
    localparam int AW    = 32;
    localparam int LW    = 6;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wcmd_valid, wcmd_ready, rcmd_valid, rcmd_ready;
    logic [AW-1:0] wcmd_addr, rcmd_addr;
    logic [LW-1:0] wcmd_len, rcmd_len;
    logic          wvalid, wready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [31:0]   wr_beats, rd_beats;

    umai_mem_target #(
        .DataWidth(DW),
        .AddrWidth(AW),
        .LenWidth (LW),
        .Depth    (DEPTH)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_umai_wcmd_valid(wcmd_valid),
        .o_umai_wcmd_ready(wcmd_ready),
        .i_umai_wcmd_addr (wcmd_addr),
        .i_umai_wcmd_len  (wcmd_len),
        .i_umai_rcmd_valid(rcmd_valid),
        .o_umai_rcmd_ready(rcmd_ready),
        .i_umai_rcmd_addr (rcmd_addr),
        .i_umai_rcmd_len  (rcmd_len),
        .i_umai_wvalid    (wvalid),
        .o_umai_wready    (wready),
        .i_umai_wdata     (wdata),
        .o_umai_rvalid    (rvalid),
        .i_umai_rready    (rready),
        .o_umai_rdata     (rdata),
        .o_wr_beats       (wr_beats),
        .o_rd_beats       (rd_beats)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: word contents, which words hold known data, last contention winner.
    logic [DW-1:0] model_mem [DEPTH];
    bit            model_known [DEPTH];
    bit            read_has_prio = 1'b0;
    longint        exp_wr = 0;
    longint        exp_rd = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input longint v);
`ifdef UMAI_MEM_TARGET_PERF_CNT_EN
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
`else
        return 32'(v) & 32'd0;
`endif
    endfunction

    task automatic chk_counters(input string tag);
        chk({tag, "_wr_beats"}, 64'(wr_beats), 64'(exp_cnt(exp_wr)));
        chk({tag, "_rd_beats"}, 64'(rd_beats), 64'(exp_cnt(exp_rd)));
    endtask

    // Present command(s) from IDLE; returns which type the model says wins.
    task automatic issue(input bit want_w, input bit want_r, input int waddr, input int wlen,
                         input int raddr, input int rlen, output bit got_w);
        wcmd_valid = want_w;
        wcmd_addr  = AW'(waddr);
        wcmd_len   = LW'(wlen);
        rcmd_valid = want_r;
        rcmd_addr  = AW'(raddr);
        rcmd_len   = LW'(rlen);
        #1;
        chk("idle_wcmd_ready", 64'(wcmd_ready), 64'(!want_r || !read_has_prio));
        chk("idle_rcmd_ready", 64'(rcmd_ready), 64'(!want_w || read_has_prio));
        got_w = want_w && (!want_r || !read_has_prio);
        @(posedge clk);
        #1;
        wcmd_valid = 1'b0;
        rcmd_valid = 1'b0;
        if (want_w && want_r) read_has_prio = !read_has_prio;
        chk("grant_wready", 64'(wready), 64'(got_w));
        chk("grant_rvalid", 64'(rvalid), 64'(!got_w));
        chk("busy_wcmd_ready", 64'(wcmd_ready), 64'd0);
    endtask

    // Deliver beats; stop_at >= 0 abandons the burst before that beat.
    task automatic wbeats(input int addr, input int len, input int stop_at, input bit gaps);
        logic [DW-1:0] d;
        for (int b = 0; b <= len; b++) begin
            if (b == stop_at) begin
                wvalid = 1'b0;
                return;
            end
            if (gaps && $urandom_range(0, 2) == 0) begin
                wvalid = 1'b0;
                @(posedge clk);
                #1;
                chk("wgap_wready", 64'(wready), 64'd1);
            end
            d      = {$urandom(), $urandom()};
            wvalid = 1'b1;
            wdata  = d;
            chk("wbeat_wready", 64'(wready), 64'd1);
            @(posedge clk);
            #1;
            model_mem[(addr + b) % DEPTH]   = d;
            model_known[(addr + b) % DEPTH] = 1'b1;
            exp_wr++;
        end
        wvalid = 1'b0;
        chk("wdone_wready", 64'(wready), 64'd0);
        chk("wdone_wcmd_ready", 64'(wcmd_ready), 64'd1);
        chk_counters("wdone");
    endtask

    // mode 0: rready always 1; mode 1: random stalls; mode 2: pattern 1,0,0,1,0,0,...
    task automatic rbeats(input int addr, input int len, input int mode, input int stop_at);
        int idx;
        int stalls;
        for (int b = 0; b <= len; b++) begin
            if (b == stop_at) return;
            idx    = (addr + b) % DEPTH;
            stalls = (mode == 0) ? 0 : (mode == 1) ? int'($urandom_range(0, 2)) : (b == 0 ? 0 : 2);
            for (int s = 0; s < stalls; s++) begin
                rready = 1'b0;
                chk("rstall_rvalid", 64'(rvalid), 64'd1);
                if (model_known[idx]) chk("rstall_rdata", 64'(rdata), 64'(model_mem[idx]));
                @(posedge clk);
                #1;
            end
            chk("rbeat_rvalid", 64'(rvalid), 64'd1);
            if (model_known[idx]) chk("rbeat_rdata", 64'(rdata), 64'(model_mem[idx]));
            rready = 1'b1;
            @(posedge clk);
            #1;
            rready = 1'b0;
            exp_rd++;
        end
        chk("rdone_rvalid", 64'(rvalid), 64'd0);
        chk("rdone_rcmd_ready", 64'(rcmd_ready), 64'd1);
        chk_counters("rdone");
    endtask

    task automatic write_burst(input int addr, input int len, input bit gaps);
        bit g;
        issue(1'b1, 1'b0, addr, len, 0, 0, g);
        wbeats(addr, len, -1, gaps);
    endtask

    task automatic read_burst(input int addr, input int len, input int mode);
        bit g;
        issue(1'b0, 1'b1, 0, 0, addr, len, g);
        rbeats(addr, len, mode, -1);
    endtask

    task automatic contend(input int waddr, input int wlen, input int raddr, input int rlen);
        bit g;
        issue(1'b1, 1'b1, waddr, wlen, raddr, rlen, g);
        if (g) wbeats(waddr, wlen, -1, 1'b0);
        else rbeats(raddr, rlen, 0, -1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        wvalid = 1'b0;
        rready = 1'b0;
        #1;
        read_has_prio = 1'b0;
        exp_wr = 0;
        exp_rd = 0;
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_wcmd_ready", 64'(wcmd_ready), 64'd1);
        chk("rst_rcmd_ready", 64'(rcmd_ready), 64'd1);
        chk_counters("rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_wcmd_ready", 64'(wcmd_ready), 64'd1);
        chk("post_rst_rcmd_ready", 64'(rcmd_ready), 64'd1);
    endtask

    initial begin
        bit g;
        wcmd_valid = 1'b1;
        rcmd_valid = 1'b1;
        wcmd_addr  = '0;
        rcmd_addr  = '0;
        wcmd_len   = '0;
        rcmd_len   = '0;
        wvalid     = 1'b0;
        wdata      = '0;
        rready     = 1'b0;
        #1;
        // Both valids in reset: IDLE equations with write priority.
        chk("rst_both_wcmd_ready", 64'(wcmd_ready), 64'd1);
        chk("rst_both_rcmd_ready", 64'(rcmd_ready), 64'd0);
        wcmd_valid = 1'b0;
        rcmd_valid = 1'b0;
        apply_reset();

        // Basic loop-back.
        write_burst('h10, 3, 1'b0);
        read_burst('h10, 3, 0);

        // Wrap at the top of memory, with an aliased upper address bit on read.
        write_burst('hFE, 3, 1'b0);
        read_burst('h1FE, 3, 0);
        read_burst('h00, 1, 0);

        // Round-robin under contention: W, then R, then W.
        contend('h20, 1, 'h10, 3);
        contend('h30, 2, 'h20, 1);
        contend('h30, 2, 'h20, 1);
        read_burst('h30, 2, 1);

        // Backpressure pattern on an 8-beat read.
        write_burst('h50, 7, 1'b1);
        read_burst('h50, 7, 2);

        // Reset during a write burst, then normal service.
        issue(1'b1, 1'b0, 'h40, 7, 0, 0, g);
        wbeats('h40, 7, 2, 1'b0);
        apply_reset();
        read_burst('h40, 1, 0);

        // Reset during a read burst.
        issue(1'b0, 1'b1, 0, 0, 'h50, 7, g);
        rbeats('h50, 7, 0, 2);
        apply_reset();
        write_burst('h60, 0, 1'b0);
        read_burst('h60, 0, 0);

`ifdef UMAI_MEM_TARGET_PERF_CNT_EN
        // Counter saturation.
        issue(1'b1, 1'b0, 'h70, 3, 0, 0, g);
        force dut.wr_beats_q = 32'hFFFF_FFFE;
        #1;
        release dut.wr_beats_q;
        exp_wr = 64'hFFFF_FFFE;
        wbeats('h70, 3, -1, 1'b0);
        chk("sat_wr_beats", 64'(wr_beats), 64'hFFFF_FFFF);
`endif

        // Randomized mix.
        for (int i = 0; i < 40; i++) begin
            int kind;
            int wa, wl, ra, rl;
            kind = int'($urandom_range(0, 2));
            wa   = int'($urandom_range(0, 511));
            wl   = int'($urandom_range(0, 7));
            ra   = int'($urandom_range(0, 511));
            rl   = int'($urandom_range(0, 7));
            if (kind == 0) write_burst(wa, wl, 1'($urandom_range(0, 1)));
            else if (kind == 1) read_burst(ra, rl, int'($urandom_range(0, 1)));
            else contend(wa, wl, ra, rl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
